// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: state encoding and default widths shared by the arbitrated Wishbone master
package wb_arb_pkg;
    typedef enum logic [1:0] {IDLE, REQ, BUS, RSP} state_t;
    localparam int AW_DEF      = 32;
    localparam int DW_DEF      = 32;
    localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/wb_timeout_cnt.sv
// wb_timeout_cnt: wait-cycle counter that flags the cycle in which TIMEOUT waits have elapsed
// ports: clk/rst clock and sync reset; clr_i zeroes the count; en_i counts one waiting cycle; expired_o is high on the TIMEOUT-th enabled cycle
module wb_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int W = $clog2(TIMEOUT + 1);
    logic [W-1:0] cnt_q, cnt_d;
    assign cnt_d = clr_i ? '0 : en_i ? cnt_q + W'(1) : cnt_q;
    always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
    // the current waiting cycle is number cnt_q+1, so expiry fires on that cycle rather than one later
    assign expired_o = en_i && ({1'b0, cnt_q} + (W+1)'(1) == (W+1)'(TIMEOUT));
endmodule

// File: rtl/wb_arb_master.sv
// wb_arb_master: burst command to Wishbone classic master that holds its arbiter grant for the whole burst
// ports: cmd_* command in; wdat_* write-data stream in; rsp_* per-beat response out;
//        arb_req/arb_gnt arbiter request and grant; wb_*_o / wb_*_i Wishbone classic master bus
module wb_arb_master
    import wb_arb_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [DW/8-1:0] cmd_sel,
    input  logic [3:0]      cmd_len,
    input  logic            wdat_valid,
    output logic            wdat_ready,
    input  logic [DW-1:0]   wdat,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_dat,
    output logic            rsp_err,
    output logic            rsp_last,
    output logic            arb_req,
    input  logic            arb_gnt,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [AW-1:0]   wb_adr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [DW/8-1:0] wb_sel_o,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic            wb_ack_i,
    input  logic            wb_err_i
);
    localparam int SW = DW / 8;
    state_t        state_q, state_d;
    logic          we_q, we_d, cmd_ready_q, cmd_ready_d, wdat_ready_q, wdat_ready_d;
    logic          stb_q, stb_d, cyc_q, cyc_d, req_q, req_d;
    logic          rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, rsp_last_q, rsp_last_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [3:0]    len_q, len_d, beat_q, beat_d;
    logic [DW-1:0] wdat_q, wdat_d, rsp_dat_q, rsp_dat_d;
    logic          expired, done;
    assign done = wb_ack_i || wb_err_i;
    wb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (!stb_q),
        .en_i      (stb_q && !done),
        .expired_o (expired)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            adr_q        <= '0;
            sel_q        <= '0;
            len_q        <= '0;
            beat_q       <= '0;
            wdat_q       <= '0;
            cmd_ready_q  <= 1'b1;
            wdat_ready_q <= 1'b0;
            stb_q        <= 1'b0;
            cyc_q        <= 1'b0;
            req_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_last_q   <= 1'b0;
            rsp_dat_q    <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            sel_q        <= sel_d;
            len_q        <= len_d;
            beat_q       <= beat_d;
            wdat_q       <= wdat_d;
            cmd_ready_q  <= cmd_ready_d;
            wdat_ready_q <= wdat_ready_d;
            stb_q        <= stb_d;
            cyc_q        <= cyc_d;
            req_q        <= req_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_last_q   <= rsp_last_d;
            rsp_dat_q    <= rsp_dat_d;
        end
    end
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        adr_d        = adr_q;
        sel_d        = sel_q;
        len_d        = len_q;
        beat_d       = beat_q;
        wdat_d       = wdat_q;
        cmd_ready_d  = cmd_ready_q;
        wdat_ready_d = 1'b0;
        stb_d        = stb_q;
        cyc_d        = cyc_q;
        req_d        = req_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_err_d    = rsp_err_q;
        rsp_last_d   = rsp_last_q;
        rsp_dat_d    = rsp_dat_q;
        case (state_q)
            IDLE: if (cmd_valid && cmd_ready_q) begin
                we_d        = cmd_we;
                adr_d       = cmd_adr;
                sel_d       = cmd_sel;
                len_d       = cmd_len;
                beat_d      = '0;
                req_d       = 1'b1;
                cmd_ready_d = 1'b0;
                state_d     = REQ;
            end
            REQ: if (arb_gnt) begin
                cyc_d        = 1'b1;
                stb_d        = !we_q;
                wdat_ready_d = we_q;
                state_d      = BUS;
            end
            BUS: begin
                if (!arb_gnt) begin
                    // grant lost: release the bus now and report a terminal error
                    stb_d       = 1'b0;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_last_d  = 1'b1;
                    rsp_dat_d   = '0;
                    state_d     = RSP;
                end else if (stb_q) begin
                    if (done || expired) begin
                        // err wins over ack; neither means the wait expired
                        stb_d       = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = wb_err_i || !wb_ack_i;
                        rsp_last_d  = wb_err_i || !wb_ack_i || beat_q == len_q;
                        rsp_dat_d   = (we_q || !done) ? '0 : wb_dat_i;
                        state_d     = RSP;
                    end
                end else if (wdat_ready_q && wdat_valid) begin
                    wdat_d = wdat;
                    stb_d  = 1'b1;
                end else begin
                    wdat_ready_d = 1'b1;
                end
            end
            RSP: if (rsp_ready) begin
                rsp_valid_d = 1'b0;
                if (rsp_last_q) begin
                    cyc_d       = 1'b0;
                    req_d       = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    adr_d        = adr_q + AW'(SW);
                    beat_d       = beat_q + 4'd1;
                    stb_d        = !we_q;
                    wdat_ready_d = we_q;
                    state_d      = BUS;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    assign cmd_ready  = cmd_ready_q;
    assign wdat_ready = wdat_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_dat    = rsp_dat_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_last   = rsp_last_q;
    assign arb_req    = req_q;
    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = stb_q;
    assign wb_we_o    = we_q;
    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = wdat_q;
    assign wb_sel_o   = sel_q;
endmodule

// File: tb/tb_wb_arb_master.sv
// tb_wb_arb_master: scoreboard bench with a behavioural arbiter, Wishbone slave and response sink
module tb_wb_arb_master;
    typedef struct packed { logic [31:0] adr; logic we; logic [3:0] sel; logic [31:0] dat; } bus_t;
    typedef struct packed { logic [31:0] dat; logic err; logic last; } rsp_t;
    logic        clk = 0, rst = 1;
    logic        cmd_valid = 0, cmd_ready, cmd_we = 0;
    logic [31:0] cmd_adr = 0;
    logic [3:0]  cmd_sel = 0, cmd_len = 0;
    logic        wdat_valid = 0, wdat_ready;
    logic [31:0] wdat = 0;
    logic        rsp_valid, rsp_ready = 1, rsp_err, rsp_last;
    logic [31:0] rsp_dat;
    logic        arb_req, arb_gnt = 0;
    logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i = 0, wb_err_i = 0;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i = 0;
    logic [3:0]  wb_sel_o;
    int errors = 0, checks = 0;
    int gnt_lat = 1, ack_lat = 1, err_beat = 0, bp_len = 0;
    int gcnt = 0, wcnt = 0, bnum = 0, bp = 0, nrsp = 0, stb_cycles = 0, req_falls = 0;
    bit mute = 0, req_prev = 0, w_take = 0, in_rsp = 0, have_snap = 0;
    bus_t b;
    rsp_t r, snap;
    bus_t exp_bus[$];
    rsp_t exp_rsp[$];
    logic [31:0] wq[$];
    wb_arb_master #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
        .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_err(rsp_err), .rsp_last(rsp_last),
        .arb_req(arb_req), .arb_gnt(arb_gnt),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic exp_beat(input logic [31:0] adr, input logic we, input logic [3:0] sel, input logic [31:0] dat);
        exp_bus.push_back('{adr: adr, we: we, sel: sel, dat: dat});
    endtask
    task automatic exp_r(input logic [31:0] dat, input logic err, input logic last);
        exp_rsp.push_back('{dat: dat, err: err, last: last});
    endtask
    task automatic run(input logic we, input logic [31:0] adr, input logic [3:0] sel, input logic [3:0] len);
        int n;
        bnum = 0;
        cmd_valid = 1; cmd_we = we; cmd_adr = adr; cmd_sel = sel; cmd_len = len;
        @(posedge clk); #2;
        cmd_valid = 0;
        check("cmd_ready_busy", cmd_ready, 0);
        n = 0;
        while ((exp_rsp.size() > 0 || !cmd_ready) && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        check("burst_done_in_time", n < 200, 1);
    endtask
    // arbiter, write-data source, Wishbone slave and response sink all act on the falling edge
    always @(negedge clk) begin
        gcnt = arb_req ? gcnt + 1 : 0;
        arb_gnt = arb_req && gcnt > gnt_lat;
        if (req_prev && !arb_req) req_falls++;
        req_prev = arb_req;
        if (w_take) void'(wq.pop_front());
        wdat_valid = wq.size() > 0;
        wdat = wdat_valid ? wq[0] : '0;
        w_take = wdat_valid && wdat_ready;
        wb_ack_i = 0; wb_err_i = 0; wb_dat_i = '0;
        if (wb_stb_o) begin
            stb_cycles++;
            if (!mute && wcnt == ack_lat) begin
                wcnt = 0;
                bnum++;
                if (exp_bus.size() == 0) check("bus_unexpected", 1, 0);
                else begin
                    b = exp_bus.pop_front();
                    check("wb_adr", wb_adr_o, b.adr);
                    check("wb_we", wb_we_o, b.we);
                    check("wb_sel", wb_sel_o, b.sel);
                    check("wb_cyc", wb_cyc_o, 1);
                    if (b.we) check("wb_dat", wb_dat_o, b.dat);
                    if (bnum == err_beat) wb_err_i = 1;
                    else begin
                        wb_ack_i = 1;
                        wb_dat_i = b.we ? '0 : b.dat;
                    end
                end
            end else wcnt++;
        end else wcnt = 0;
        if (rsp_valid && !in_rsp) begin
            in_rsp = 1; bp = bp_len; have_snap = 0;
        end
        rsp_ready = !(rsp_valid && bp > 0);
        if (rsp_valid && bp > 0) begin
            bp--;
            if (have_snap) begin
                check("hold_dat", rsp_dat, snap.dat);
                check("hold_err", rsp_err, snap.err);
                check("hold_last", rsp_last, snap.last);
            end else begin
                snap = '{dat: rsp_dat, err: rsp_err, last: rsp_last};
                have_snap = 1;
            end
        end
        if (rsp_valid && rsp_ready) begin
            nrsp++;
            in_rsp = 0;
            if (exp_rsp.size() == 0) check("rsp_unexpected", 1, 0);
            else begin
                r = exp_rsp.pop_front();
                check("rsp_dat", rsp_dat, r.dat);
                check("rsp_err", rsp_err, r.err);
                check("rsp_last", rsp_last, r.last);
            end
        end
    end
    initial begin
        int n0, f0, n;
        repeat (3) @(posedge clk);
        #2;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_wdat_ready", wdat_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_last", rsp_last, 0);
        check("rst_rsp_dat", rsp_dat, 0);
        check("rst_arb_req", arb_req, 0);
        check("rst_cyc", wb_cyc_o, 0);
        check("rst_stb", wb_stb_o, 0);
        check("rst_we", wb_we_o, 0);
        check("rst_adr", wb_adr_o, 0);
        check("rst_wdat", wb_dat_o, 0);
        check("rst_sel", wb_sel_o, 0);
        rst = 0;
        @(posedge clk); #2;
        n0 = nrsp;
        exp_beat(32'h100, 0, 4'hF, 32'hDEADBEEF);
        exp_r(32'hDEADBEEF, 0, 1);
        run(0, 32'h100, 4'hF, 4'd0);
        check("single_rsp_count", nrsp - n0, 1);
        check("single_arb_req_low", arb_req, 0);
        check("single_cyc_low", wb_cyc_o, 0);
        n0 = nrsp; f0 = req_falls;
        for (int i = 0; i < 4; i++) begin
            wq.push_back(32'(i + 1));
            exp_beat(32'h1000 + 32'(4 * i), 1, 4'h3, 32'(i + 1));
            exp_r(32'h0, 0, i == 3);
        end
        run(1, 32'h1000, 4'h3, 4'd3);
        check("write_rsp_count", nrsp - n0, 4);
        check("write_req_single_drop", req_falls - f0, 1);
        check("write_data_consumed", wq.size(), 0);
        exp_beat(32'hFFFF_FFFC, 0, 4'hF, 32'hA5A5_A5A5);
        exp_beat(32'h0000_0000, 0, 4'hF, 32'h5A5A_5A5A);
        exp_r(32'hA5A5_A5A5, 0, 0);
        exp_r(32'h5A5A_5A5A, 0, 1);
        run(0, 32'hFFFF_FFFC, 4'hF, 4'd1);
        check("wrap_bus_done", exp_bus.size(), 0);
        mute = 1; stb_cycles = 0; n0 = nrsp;
        exp_r(32'h0, 1, 1);
        run(0, 32'h40, 4'hF, 4'd2);
        check("timeout_stb_cycles", stb_cycles, 4);
        check("timeout_rsp_count", nrsp - n0, 1);
        check("timeout_cyc_low", wb_cyc_o, 0);
        check("timeout_arb_req_low", arb_req, 0);
        mute = 0;
        err_beat = 2; bp_len = 5; n0 = nrsp;
        exp_beat(32'h200, 0, 4'hF, 32'h11);
        exp_beat(32'h204, 0, 4'hF, 32'h22);
        exp_r(32'h11, 0, 0);
        exp_r(32'h0, 1, 1);
        run(0, 32'h200, 4'hF, 4'd2);
        check("err_rsp_count", nrsp - n0, 2);
        check("err_bus_done", exp_bus.size(), 0);
        err_beat = 0; bp_len = 0;
        mute = 1; n0 = nrsp;
        cmd_valid = 1; cmd_we = 0; cmd_adr = 32'h300; cmd_sel = 4'hF; cmd_len = 4'd3;
        @(posedge clk); #2;
        cmd_valid = 0;
        n = 0;
        while (!wb_stb_o && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        check("midrst_stb_seen", wb_stb_o, 1);
        rst = 1;
        @(posedge clk); #2;
        check("midrst_cyc", wb_cyc_o, 0);
        check("midrst_stb", wb_stb_o, 0);
        check("midrst_arb_req", arb_req, 0);
        check("midrst_cmd_ready", cmd_ready, 1);
        rst = 0;
        repeat (10) @(posedge clk);
        #2;
        check("midrst_no_rsp", nrsp - n0, 0);
        check("midrst_rsp_valid", rsp_valid, 0);
        mute = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
